// File: rtl/issue_if.sv
// Decode/execute issue handshake bundle for the issue scoreboard.
// The master side drives decode, writeback and branch inputs; the slave side is the controller.
interface issue_if #(
  parameter int ra_wd  = 5,
  parameter int cnt_wd = 3
);
  logic              i_dec_valid;
  logic              o_dec_ready;
  logic [ra_wd-1:0]  i_rs1;
  logic              i_rs1_used;
  logic [ra_wd-1:0]  i_rs2;
  logic              i_rs2_used;
  logic [ra_wd-1:0]  i_rd;
  logic              i_rd_we;
  logic              i_multicycle;
  logic              o_issue;
  logic              o_stall;
  logic              i_wb_valid;
  logic [ra_wd-1:0]  i_wb_rd;
  logic              i_br_taken;
  logic [cnt_wd-1:0] o_inflight;

  modport master (
    output i_dec_valid, i_rs1, i_rs1_used, i_rs2, i_rs2_used, i_rd, i_rd_we,
           i_multicycle, i_wb_valid, i_wb_rd, i_br_taken,
    input  o_dec_ready, o_issue, o_stall, o_inflight
  );

  modport slave (
    input  i_dec_valid, i_rs1, i_rs1_used, i_rs2, i_rs2_used, i_rd, i_rd_we,
           i_multicycle, i_wb_valid, i_wb_rd, i_br_taken,
    output o_dec_ready, o_issue, o_stall, o_inflight
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: busy-register scoreboard for multi-cycle ops, RAW/WAW stall,
// post-branch flush bubbles and a bound on the number of in-flight multi-cycle ops.
module issue_scoreboard #(
  parameter int n_regs_p    = 32,
  parameter int max_pend_p  = 4,
  parameter int flush_cyc_p = 1
) (
  input logic   clk,
  input logic   rst,
  issue_if.slave bus
);
  localparam int ra_wd  = $clog2(n_regs_p);
  localparam int cnt_wd = $clog2(max_pend_p + 1);
  localparam int fc_wd  = (flush_cyc_p > 1) ? $clog2(flush_cyc_p) : 1;

  typedef enum logic {
    st_run,
    st_flush
  } state_t;

  state_t             state;
  logic [fc_wd-1:0]   flush_cnt;
  logic [n_regs_p-1:0] busy;
  logic [n_regs_p-1:0] busy_nxt;
  logic [n_regs_p-1:0] wb_mask;
  logic [n_regs_p-1:0] eb;
  logic [cnt_wd-1:0]  inflight;
  logic [cnt_wd-1:0]  inflight_nxt;
  logic               hazard;
  logic               full;
  logic               dec_ready;
  logic               issue;
  logic               cnt_inc;
  logic               cnt_dec;

  // A retiring writeback is forwarded: its register stops blocking in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wb_mask = '0;
    if (bus.i_wb_valid) wb_mask[bus.i_wb_rd] = 1'b1;
  end

  assign eb = busy & ~wb_mask;

  assign hazard = (bus.i_rs1_used & (bus.i_rs1 != '0) & eb[bus.i_rs1])
                | (bus.i_rs2_used & (bus.i_rs2 != '0) & eb[bus.i_rs2])
                | (bus.i_rd_we    & (bus.i_rd  != '0) & eb[bus.i_rd]);

  assign full = bus.i_multicycle & (inflight == cnt_wd'(max_pend_p)) & ~bus.i_wb_valid;

  assign dec_ready = ~rst & (state == st_run) & ~bus.i_br_taken & ~hazard & ~full;
  assign issue     = bus.i_dec_valid & dec_ready;

  assign bus.o_dec_ready = dec_ready;
  assign bus.o_issue     = issue;
  assign bus.o_stall     = ~rst & bus.i_dec_valid & ~dec_ready;
  assign bus.o_inflight  = inflight;

  assign cnt_inc = issue & bus.i_multicycle;
  assign cnt_dec = bus.i_wb_valid & (inflight != '0);

  // Clear from writeback first, then set from issue, so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy & ~wb_mask;
    if (cnt_inc && bus.i_rd_we && (bus.i_rd != '0)) busy_nxt[bus.i_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    inflight_nxt = inflight;
    unique case ({cnt_inc, cnt_dec})
      2'b10:   inflight_nxt = inflight + cnt_wd'(1);
      2'b01:   inflight_nxt = inflight - cnt_wd'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  // The busy bitmap is a flop vector, not a RAM, so it is safely cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      inflight <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      busy     <= busy_nxt;
      inflight <= inflight_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= st_run;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        st_run: begin
          if (bus.i_br_taken) begin
            state     <= st_flush;
            flush_cnt <= fc_wd'(flush_cyc_p - 1);
          end
        end
        st_flush: begin
          // A branch resolved during a flush restarts the bubble count.
          if (bus.i_br_taken) begin
            flush_cnt <= fc_wd'(flush_cyc_p - 1);
          end else if (flush_cnt == '0) begin
            state <= st_run;
          end else begin
            flush_cnt <= flush_cnt - fc_wd'(1);
          end
        end
        default: begin
          state     <= st_run;
          flush_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vector table, a mid-flight
// reset sequence, and randomized traffic against a set/count reference model.
module tb_issue_scoreboard;
  localparam int N    = 32;
  localparam int RA   = 5;
  localparam int CW   = 3;
  localparam int MAXP = 4;
  localparam int FC   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_if #(.ra_wd(RA), .cnt_wd(CW)) bus ();

  issue_scoreboard #(.n_regs_p(N), .max_pend_p(MAXP), .flush_cyc_p(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic mc; logic wbv; logic [4:0] wbrd; logic br;
    logic er; logic es; int ei;
  } vec_t;

  function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                              input logic u2, input int rd, input logic we, input logic mc,
                              input logic wbv, input int wbrd, input logic br,
                              input logic er, input logic es, input int ei);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
    t.rd = 5'(rd); t.we = we; t.mc = mc; t.wbv = wbv; t.wbrd = 5'(wbrd); t.br = br;
    t.er = er; t.es = es; t.ei = ei;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.i_dec_valid  = t.v;
    bus.i_rs1        = t.rs1;
    bus.i_rs1_used   = t.u1;
    bus.i_rs2        = t.rs2;
    bus.i_rs2_used   = t.u2;
    bus.i_rd         = t.rd;
    bus.i_rd_we      = t.we;
    bus.i_multicycle = t.mc;
    bus.i_wb_valid   = t.wbv;
    bus.i_wb_rd      = t.wbrd;
    bus.i_br_taken   = t.br;
  endtask

  // Reference model: a set of busy registers, an in-flight count, bubbles still owed.
  bit busy_m[N];
  int infl_m;
  int bub_m;

  task automatic model_reset();
    for (int i = 0; i < N; i++) busy_m[i] = 1'b0;
    infl_m = 0;
    bub_m  = 0;
  endtask

  function automatic bit blocked(input int r);
    if (r == 0) return 1'b0;
    if (bus.i_wb_valid && int'(bus.i_wb_rd) == r) return 1'b0;
    return busy_m[r];
  endfunction

  function automatic bit model_ready();
    bit hz, fl;
    if (rst) return 1'b0;
    hz = (bus.i_rs1_used && blocked(int'(bus.i_rs1))) ||
         (bus.i_rs2_used && blocked(int'(bus.i_rs2))) ||
         (bus.i_rd_we    && blocked(int'(bus.i_rd)));
    fl = bus.i_multicycle && infl_m == MAXP && !bus.i_wb_valid;
    return bub_m == 0 && !bus.i_br_taken && !hz && !fl;
  endfunction

  task automatic advance();
    bit iss, inc, dec;
    iss = bus.i_dec_valid && model_ready();
    inc = iss && bus.i_multicycle;
    dec = bus.i_wb_valid && infl_m > 0;
    @(posedge clk);
    if (bus.i_wb_valid) busy_m[int'(bus.i_wb_rd)] = 1'b0;
    if (inc && bus.i_rd_we && bus.i_rd != 0) busy_m[int'(bus.i_rd)] = 1'b1;
    infl_m = infl_m + int'(inc) - int'(dec);
    if (bus.i_br_taken) bub_m = FC;
    else if (bub_m > 0) bub_m--;
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    //          v rs1 u1 rs2 u2 rd we mc wbv wbrd br  er es ei
    tbl.push_back(mk(1, 3, 1, 4, 1, 6, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 5, 0, 1, 0, 1));
    tbl.push_back(mk(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 1, 1, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 0, 0));

    // Outputs held low under reset even with a valid op presented.
    drive(tbl[0]);
    model_reset();
    #12;
    check("rst_ready", bus.o_dec_ready, 0);
    check("rst_issue", bus.o_issue, 0);
    check("rst_stall", bus.o_stall, 0);
    check("rst_inflight", bus.o_inflight, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      @(negedge clk);
      check($sformatf("tbl%0d_ready", k), bus.o_dec_ready, tbl[k].er);
      check($sformatf("tbl%0d_stall", k), bus.o_stall, tbl[k].es);
      check($sformatf("tbl%0d_issue", k), bus.o_issue, tbl[k].v & tbl[k].er);
      check($sformatf("tbl%0d_inflight", k), bus.o_inflight, tbl[k].ei);
      advance();
    end

    // Mid-flight reset with busy[7] set and two ops outstanding.
    drive(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 0, 0));
    advance();
    drive(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 1, 0, 0));
    advance();
    drive(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    @(negedge clk);
    check("pre_rst_inflight", bus.o_inflight, 2);
    check("pre_rst_stall", bus.o_stall, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", bus.o_dec_ready, 0);
    check("mid_rst_issue", bus.o_issue, 0);
    check("mid_rst_stall", bus.o_stall, 0);
    check("mid_rst_inflight", bus.o_inflight, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    advance();
    @(negedge clk);
    check("post_rst_wb_inflight", bus.o_inflight, 0);
    drive(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    check("post_rst_rs7_ready", bus.o_dec_ready, 1);
    advance();

    // Randomized traffic against the reference model.
    drive(idle);
    for (int c = 0; c < 3000; c++) begin
      bus.i_dec_valid  = ($urandom_range(0, 3) != 0);
      bus.i_rs1        = 5'($urandom_range(0, 7));
      bus.i_rs1_used   = $urandom_range(0, 1) == 1;
      bus.i_rs2        = 5'($urandom_range(0, 7));
      bus.i_rs2_used   = $urandom_range(0, 1) == 1;
      bus.i_rd         = 5'($urandom_range(0, 7));
      bus.i_rd_we      = $urandom_range(0, 1) == 1;
      bus.i_multicycle = ($urandom_range(0, 2) == 0);
      bus.i_wb_valid   = ($urandom_range(0, 2) == 0);
      bus.i_wb_rd      = 5'($urandom_range(0, 7));
      bus.i_br_taken   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check("rnd_ready", bus.o_dec_ready, model_ready());
      check("rnd_issue", bus.o_issue, bus.i_dec_valid & model_ready());
      check("rnd_stall", bus.o_stall, bus.i_dec_valid & ~model_ready());
      check("rnd_inflight", bus.o_inflight, infl_m);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
